// File: rtl/blueman_pkg.sv
// Shared definitions for the blueman game: game-state codes, directions,
// mover FSM states and default screen geometry.
package blueman_pkg;

  localparam logic [1:0] GS_START   = 2'b00;
  localparam logic [1:0] GS_PLAYING = 2'b01;
  localparam logic [1:0] GS_OVER    = 2'b10;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    MV_IDLE,
    MV_HOP,
    MV_COOLDOWN
  } mover_state_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_PLAYER_W = 16;
  localparam int DEF_PLAYER_H = 16;

  // Simultaneous presses resolve as up > down > left > right.
  function automatic dir_t pick_dir(input logic [3:0] edges);
    if (edges[3])      return UP;
    else if (edges[2]) return DOWN;
    else if (edges[1]) return LEFT;
    else               return RIGHT;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector; a level held high yields a single pulse.
module btn_edge_detect #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] din_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_prev <= '0;
      rise     <= '0;
    end else begin
      din_prev <= din;
      rise     <= din & ~din_prev;
    end
  end

endmodule

// File: rtl/player_mover.sv
// Owns the player position: turns button edges into animated tile hops,
// clamped to the screen, gated by game state, and tracks forward progress.
module player_mover
  import blueman_pkg::*;
#(
  parameter int SCREEN_W        = DEF_SCREEN_W,
  parameter int SCREEN_H        = DEF_SCREEN_H,
  parameter int PLAYER_W        = DEF_PLAYER_W,
  parameter int PLAYER_H        = DEF_PLAYER_H,
  parameter int TILE            = 32,
  parameter int HOP_FRAMES      = 4,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int SPAWN_X         = 312,
  parameter int SPAWN_Y         = 448
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] game_state,
  input  logic [3:0] btn,
  output logic [9:0] player_x,
  output logic [8:0] player_y,
  output logic       moving,
  output logic       hop_done,
  output logic [1:0] facing,
  output logic [7:0] score
);

  localparam logic [9:0] TILE_X  = 10'(TILE);
  localparam logic [8:0] TILE_Y  = 9'(TILE);
  localparam logic [9:0] STEP_X  = 10'(TILE / HOP_FRAMES);
  localparam logic [8:0] STEP_Y  = 9'(TILE / HOP_FRAMES);
  localparam logic [9:0] X_HI    = 10'(SCREEN_W - PLAYER_W - TILE);
  localparam logic [8:0] Y_HI    = 9'(SCREEN_H - PLAYER_H - TILE);
  localparam logic [9:0] SPAWN_XV = 10'(SPAWN_X);
  localparam logic [8:0] SPAWN_YV = 9'(SPAWN_Y);
  localparam logic [7:0] HOP_LAST = 8'(HOP_FRAMES - 1);
  localparam logic [7:0] CD_LAST  = 8'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  logic [3:0]   btn_edge;
  mover_state_t state;
  dir_t         dir;
  dir_t         sel_dir;
  logic [9:0]   target_x, next_x;
  logic [8:0]   target_y, next_y;
  logic         in_bounds;
  logic [8:0]   best_y;
  logic [7:0]   frame_cnt;

  btn_edge_detect #(.WIDTH(4)) u_edge (
    .clk   (clk),
    .reset (reset),
    .din   (btn),
    .rise  (btn_edge)
  );

  // Position is always on-screen, so one-sided checks suffice per direction.
  always_comb begin
    sel_dir   = pick_dir(btn_edge);
    next_x    = player_x;
    next_y    = player_y;
    in_bounds = 1'b0;
    unique case (sel_dir)
      UP:    begin next_y = player_y - TILE_Y; in_bounds = (player_y >= TILE_Y); end
      DOWN:  begin next_y = player_y + TILE_Y; in_bounds = (player_y <= Y_HI);   end
      LEFT:  begin next_x = player_x - TILE_X; in_bounds = (player_x >= TILE_X); end
      RIGHT: begin next_x = player_x + TILE_X; in_bounds = (player_x <= X_HI);   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_x  <= SPAWN_XV;
      player_y  <= SPAWN_YV;
      state     <= MV_IDLE;
      dir       <= UP;
      target_x  <= SPAWN_XV;
      target_y  <= SPAWN_YV;
      moving    <= 1'b0;
      hop_done  <= 1'b0;
      facing    <= 2'd0;
      score     <= 8'd0;
      best_y    <= SPAWN_YV;
      frame_cnt <= 8'd0;
    end else begin
      hop_done <= 1'b0;
      if (game_state == GS_START) begin
        player_x  <= SPAWN_XV;
        player_y  <= SPAWN_YV;
        state     <= MV_IDLE;
        moving    <= 1'b0;
        score     <= 8'd0;
        best_y    <= SPAWN_YV;
        frame_cnt <= 8'd0;
      end else if (game_state != GS_PLAYING) begin
        // OVER (and the illegal code) abandon any hop where it stands.
        state     <= MV_IDLE;
        moving    <= 1'b0;
        frame_cnt <= 8'd0;
      end else begin
        unique case (state)
          MV_IDLE: begin
            if (|btn_edge) begin
              facing <= sel_dir;
              if (in_bounds) begin
                dir       <= sel_dir;
                target_x  <= next_x;
                target_y  <= next_y;
                frame_cnt <= 8'd0;
                moving    <= 1'b1;
                state     <= MV_HOP;
              end
            end
          end
          MV_HOP: begin
            if (frame_tick) begin
              if (frame_cnt == HOP_LAST) begin
                player_x  <= target_x;
                player_y  <= target_y;
                hop_done  <= 1'b1;
                moving    <= 1'b0;
                frame_cnt <= 8'd0;
                state     <= (COOLDOWN_FRAMES == 0) ? MV_IDLE : MV_COOLDOWN;
                if (dir == UP && target_y < best_y) begin
                  best_y <= target_y;
                  if (score != 8'hFF) score <= score + 8'd1;
                end
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
                unique case (dir)
                  UP:    player_y <= player_y - STEP_Y;
                  DOWN:  player_y <= player_y + STEP_Y;
                  LEFT:  player_x <= player_x - STEP_X;
                  RIGHT: player_x <= player_x + STEP_X;
                  default: ;
                endcase
              end
            end
          end
          MV_COOLDOWN: begin
            if (frame_tick) begin
              if (frame_cnt == CD_LAST) begin
                frame_cnt <= 8'd0;
                state     <= MV_IDLE;
              end else begin
                frame_cnt <= frame_cnt + 8'd1;
              end
            end
          end
          default: state <= MV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_mover.sv
// Self-checking bench for player_mover: directed scenarios plus random hops
// checked against a hop-level reference model of position, facing and score.
module tb_player_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [1:0] game_state;
  logic [3:0] btn;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic       moving;
  logic       hop_done;
  logic [1:0] facing;
  logic [7:0] score;

  int checks = 0;
  int fails  = 0;

  int mx, my, mscore, mbest, mfacing;

  player_mover dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .game_state (game_state),
    .btn        (btn),
    .player_x   (player_x),
    .player_y   (player_y),
    .moving     (moving),
    .hop_done   (hop_done),
    .facing     (facing),
    .score      (score)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_x"}, player_x, mx);
    checkOutput({tag, "_y"}, player_y, my);
    checkOutput({tag, "_score"}, score, mscore);
    checkOutput({tag, "_facing"}, facing, mfacing);
  endtask

  task automatic modelSpawn();
    mx = 312; my = 448; mscore = 0; mbest = 448;
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    btn = mask;
    @(negedge clk);
    btn = 4'b0000;
    @(negedge clk);
  endtask

  task automatic doTick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // One complete press: predicts acceptance from the screen limits, then
  // walks the hop tick by tick and runs out the cooldown.
  task automatic doHop(input logic [3:0] mask, input bit cdPress);
    int d, dx, dy, sx, sy, tx, ty;
    d  = mask[3] ? 0 : (mask[2] ? 1 : (mask[1] ? 2 : 3));
    dx = (d == 2) ? -32 : ((d == 3) ? 32 : 0);
    dy = (d == 0) ? -32 : ((d == 1) ? 32 : 0);
    sx = mx; sy = my; tx = mx + dx; ty = my + dy;
    applyStimulus(mask);
    mfacing = d;
    checkOutput("press_facing", facing, d);
    if (tx < 0 || tx > 624 || ty < 0 || ty > 464) begin
      checkOutput("reject_moving", moving, 0);
      checkOutput("reject_x", player_x, mx);
      checkOutput("reject_y", player_y, my);
      return;
    end
    checkOutput("accept_moving", moving, 1);
    for (int k = 1; k <= 4; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      doTick();
      checkOutput("hop_x", player_x, sx + dx * k / 4);
      checkOutput("hop_y", player_y, sy + dy * k / 4);
      checkOutput("hop_done", hop_done, (k == 4));
      checkOutput("hop_moving", moving, (k < 4));
    end
    mx = tx; my = ty;
    if (d == 0 && ty < mbest) begin
      mbest = ty;
      if (mscore < 255) mscore++;
    end
    checkOutput("land_score", score, mscore);
    @(negedge clk);
    checkOutput("hop_done_pulse", hop_done, 0);
    if (cdPress) begin
      applyStimulus(4'b1000);
      @(negedge clk);
      checkOutput("cooldown_moving", moving, 0);
      checkOutput("cooldown_y", player_y, my);
    end
    repeat (2) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      doTick();
    end
    @(negedge clk);
    checkOutput("idle_moving", moving, 0);
  endtask

  initial begin
    reset = 1'b1; game_state = 2'b00; btn = 4'b0000; frame_tick = 1'b0;
    modelSpawn(); mfacing = 0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    checkOutput("reset_moving", moving, 0);
    checkOutput("reset_hop_done", hop_done, 0);
    reset = 1'b0;
    @(negedge clk);
    game_state = 2'b01;
    @(negedge clk);

    // Single up hop: 440, 432, 424, 416 with the landing pulse on tick four.
    doHop(4'b1000, 1'b0);
    checkOutput("first_hop_y", player_y, 416);
    checkOutput("first_hop_score", score, 1);

    // Asynchronous reset in the middle of a hop.
    applyStimulus(4'b1000);
    doTick(); doTick();
    checkOutput("mid_hop_y", player_y, 400);
    #2 reset = 1'b1;
    #1;
    modelSpawn(); mfacing = 0;
    checkAll("async_reset");
    checkOutput("async_reset_moving", moving, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Holding up across ten frames yields exactly one hop.
    btn = 4'b1000;
    repeat (2) @(negedge clk);
    checkOutput("hold_moving", moving, 1);
    for (int i = 0; i < 10; i++) begin
      doTick();
      @(negedge clk);
    end
    btn = 4'b0000;
    @(negedge clk);
    my = 416; mscore = 1; mbest = 416; mfacing = 0;
    checkAll("hold");
    checkOutput("hold_moving_after", moving, 0);
    doHop(4'b0100, 1'b0);
    doHop(4'b1000, 1'b0);
    checkOutput("revisit_score", score, 1);

    // Bottom and left edges reject the hop but still turn the player.
    doHop(4'b0100, 1'b0);
    doHop(4'b0100, 1'b0);
    checkOutput("bottom_y", player_y, 448);
    checkOutput("bottom_facing", facing, 1);
    for (int i = 0; i < 10; i++) doHop(4'b0010, 1'b0);
    checkOutput("left_x", player_x, 24);
    checkOutput("left_facing", facing, 2);

    // Up+left together hops vertically; a press during cooldown is ignored.
    doHop(4'b1010, 1'b1);
    checkOutput("combo_x", player_x, 24);
    checkOutput("combo_y", player_y, 416);

    // OVER two ticks into a hop freezes mid-step with no landing.
    applyStimulus(4'b1000);
    doTick(); doTick();
    my = my - 16; mfacing = 0;
    game_state = 2'b10;
    for (int i = 0; i < 6; i++) begin
      frame_tick = i[0];
      @(negedge clk);
      checkOutput("over_y", player_y, my);
      checkOutput("over_moving", moving, 0);
      checkOutput("over_hop_done", hop_done, 0);
    end
    frame_tick = 1'b0;
    game_state = 2'b11;
    applyStimulus(4'b1000);
    doTick();
    checkAll("illegal_state");
    checkOutput("illegal_moving", moving, 0);
    game_state = 2'b00;
    @(negedge clk);
    modelSpawn();
    checkAll("start");
    game_state = 2'b01;
    @(negedge clk);

    // Random presses against the hop-level model.
    for (int i = 0; i < 40; i++) begin
      doHop(4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)));
      checkAll("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
